// File: rtl/scan_sel_if.sv
// Digit-scan bus between the scan controller and the display driver.
// The master side supplies enable, mask and digit codes; the slave returns the select.
interface scan_sel_if;
   logic        en;
   logic [7:0]  digit_mask;
   logic [31:0] data;
   logic [2:0]  sel;
   logic [3:0]  nibble;
   logic        valid;
   logic        wrap;

   modport master (
      output en, digit_mask, data,
      input  sel, nibble, valid, wrap
   );

   modport slave (
      input  en, digit_mask, data,
      output sel, nibble, valid, wrap
   );
endinterface

// File: rtl/scan_sel_gen.sv
// Multiplexed 8-digit scan generator.
// Walks sel through fixed drive slots separated by optional blanking gaps.
module scan_sel_gen #(
   parameter int PRESCALE     = 4,
   parameter int BLANK_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   scan_sel_if.slave  bus
);

   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [7:0] B_LAST =
      (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      BLANK
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    sel_q, sel_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [7:0]    bcnt_q, bcnt_d;
   logic          drive_q, drive_d;
   logic          wrap_q, wrap_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         pcnt_q  <= '0;
         bcnt_q  <= 8'd0;
         drive_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pcnt_q  <= pcnt_d;
         bcnt_q  <= bcnt_d;
         drive_q <= drive_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      pcnt_d  = pcnt_q;
      bcnt_d  = bcnt_q;
      wrap_d  = 1'b0;
      if (!bus.en) begin
         // dropping enable abandons the slot without advancing
         state_d = IDLE;
         pcnt_d  = '0;
         bcnt_d  = 8'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = DRIVE;
               pcnt_d  = '0;
            end
            DRIVE: begin
               if (pcnt_q == P_LAST) begin
                  pcnt_d = '0;
                  if (BLANK_CYCLES > 0) begin
                     state_d = BLANK;
                     bcnt_d  = 8'd0;
                  end else begin
                     sel_d  = sel_q + 3'd1;
                     wrap_d = (sel_q == 3'd7);
                  end
               end else begin
                  pcnt_d = pcnt_q + PW'(1);
               end
            end
            BLANK: begin
               if (bcnt_q == B_LAST) begin
                  bcnt_d  = 8'd0;
                  state_d = DRIVE;
                  sel_d   = sel_q + 3'd1;
                  wrap_d  = (sel_q == 3'd7);
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      drive_d = (state_d == DRIVE);
   end

   // mask and data stay combinational so edits show up in the same cycle
   assign bus.sel    = sel_q;
   assign bus.valid  = drive_q & bus.digit_mask[sel_q];
   assign bus.nibble = bus.data[{sel_q, 2'b00} +: 4];
   assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: two configurations share one stimulus stream,
// checked every cycle against a slot-arithmetic model plus literal points.
module tb_scan_sel_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, rst1, en;
   logic [7:0]  mask;
   logic [31:0] data;

   scan_sel_if if0 ();
   scan_sel_if if1 ();

   assign if0.en         = en;
   assign if0.digit_mask = mask;
   assign if0.data       = data;
   assign if1.en         = en;
   assign if1.digit_mask = mask;
   assign if1.data       = data;

   scan_sel_gen #(.PRESCALE(4), .BLANK_CYCLES(2)) dut0 (
      .clk (clk),
      .rst (rst0),
      .bus (if0.slave)
   );

   scan_sel_gen #(.PRESCALE(2), .BLANK_CYCLES(0)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (if1.slave)
   );

   int errors = 0;
   int checks = 0;
   bit armed  = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // model: t counts cycles since scanning (re)started at base
   int pp [2] = '{4, 2};
   int bb [2] = '{2, 0};
   bit run [2];
   int base [2];
   int t [2];

   function automatic int msel(int i);
      if (!run[i]) return base[i];
      return (base[i] + t[i] / (pp[i] + bb[i])) % 8;
   endfunction

   function automatic bit mdrive(int i);
      return run[i] && ((t[i] % (pp[i] + bb[i])) < pp[i]);
   endfunction

   function automatic bit mwrap(int i);
      return run[i] && t[i] > 0 &&
             (t[i] % (pp[i] + bb[i])) == 0 && msel(i) == 0;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if ((i == 0) ? rst0 : rst1) begin
            run[i]  <= 1'b0;
            base[i] <= 0;
            t[i]    <= 0;
         end else if (!en) begin
            if (run[i]) base[i] <= msel(i);
            run[i] <= 1'b0;
            t[i]   <= 0;
         end else if (!run[i]) begin
            run[i] <= 1'b1;
            t[i]   <= 0;
         end else begin
            t[i] <= t[i] + 1;
         end
      end
   end

   task automatic cmp(int i, logic [2:0] s, logic v,
                      logic w, logic [3:0] n);
      logic [2:0] es;
      es = 3'(msel(i));
      chk($sformatf("d%0d sel", i), s, es);
      chk($sformatf("d%0d valid", i), v, mdrive(i) & mask[es]);
      chk($sformatf("d%0d wrap", i), w, mwrap(i));
      chk($sformatf("d%0d nibble", i), n, data[{es, 2'b00} +: 4]);
   endtask

   always @(negedge clk) begin
      if (armed) begin
         cmp(0, if0.sel, if0.valid, if0.wrap, if0.nibble);
         cmp(1, if1.sel, if1.valid, if1.wrap, if1.nibble);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int v0, v1, w0, w1;
      bit found;
      rst0 = 1'b1;
      rst1 = 1'b1;
      en   = 1'b0;
      mask = 8'hFF;
      data = 32'h7654_3210;
      step();
      armed = 1'b1;
      step();
      rst0 = 1'b0;
      rst1 = 1'b0;
      en   = 1'b1;
      @(negedge clk);
      chk("rst sel", if0.sel, 3'd0);
      chk("rst valid", if0.valid, 1'b0);
      chk("rst wrap", if0.wrap, 1'b0);
      chk("rst valid d1", if1.valid, 1'b0);

      v0 = 0; v1 = 0; w0 = 0; w1 = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (c == 20) data = 32'hFEDC_BA98;
         @(negedge clk);
         if (c < 48 && if0.valid === 1'b1) v0++;
         if (c < 16 && if1.valid === 1'b1) v1++;
         if (if0.wrap === 1'b1) w0++;
         if (if1.wrap === 1'b1) w1++;
         if (c == 0)  chk("first drive", {if0.sel, if0.valid}, 4'b0001);
         if (c == 3)  chk("slot end", {if0.sel, if0.valid}, 4'b0001);
         if (c == 4)  chk("blank 0", {if0.sel, if0.valid}, 4'b0000);
         if (c == 6)  chk("sel1", {if0.sel, if0.valid}, 4'b0011);
         if (c == 19) chk("nib old", if0.nibble, 4'h3);
         if (c == 20) chk("nib new", if0.nibble, 4'hB);
         if (c == 47) chk("pre wrap", {if0.sel, if0.wrap}, 4'b1110);
         if (c == 48) chk("wrap", {if0.sel, if0.wrap}, 4'b0001);
         if (c == 49) chk("post wrap", if0.wrap, 1'b0);
      end
      chk("valid count d0", v0, 32);
      chk("valid count d1", v1, 16);
      chk("wrap count d0", w0, 1);
      chk("wrap count d1", w1, 3);

      step();
      mask = 8'b0000_0101;
      v0 = 0; v1 = 0;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         if (if0.valid === 1'b1) v0++;
         if (c < 16 && if1.valid === 1'b1) v1++;
         step();
      end
      chk("masked count d0", v0, 8);
      chk("masked count d1", v1, 4);
      mask = 8'hFF;

      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (run[0] && msel(0) == 3 && !mdrive(0)) found = 1'b1;
      end
      chk("find blank3", found, 1'b1);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 4) en = 1'b1;
         @(negedge clk);
         chk("en low hold", {if0.sel, if0.valid}, 4'b0110);
      end
      for (int c = 0; c < 7; c++) begin
         step();
         @(negedge clk);
         if (c == 0) chk("resume", {if0.sel, if0.valid}, 4'b0111);
         if (c == 3) chk("resume end", {if0.sel, if0.valid}, 4'b0111);
         if (c == 4) chk("resume blank", {if0.sel, if0.valid}, 4'b0110);
         if (c == 6) chk("resume adv", {if0.sel, if0.valid}, 4'b1001);
      end

      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (run[1] && msel(1) == 5) found = 1'b1;
      end
      chk("find sel5", found, 1'b1);
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      @(negedge clk);
      chk("mid rst", {if1.sel, if1.valid, if1.wrap}, 5'b00000);
      step();
      @(negedge clk);
      chk("restart", {if1.sel, if1.valid}, 4'b0001);

      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (run[1] && msel(1) == 7 && (t[1] % 2) == 1) found = 1'b1;
      end
      chk("find term7", found, 1'b1);
      en = 1'b0;
      step();
      en = 1'b1;
      @(negedge clk);
      chk("en prio", {if1.sel, if1.valid, if1.wrap}, 5'b11100);

      repeat (20) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
